sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Sequences the shared SDRAM command/address bus between four command sources: power-up init, auto-refresh, burst write and burst read.
- Contains the refresh interval timer.
- Grants one source at a time and muxes that source's command and address onto the SDRAM pins.
- Sits inside the SDRAM controller, between the init/aref/write/read sub-FSMs and the pin drivers; the UART command decoder drives wr_req/rd_req.

Parameters:
- BA_BITS, 2, bank address width
- ADDR_BITS, 12, row/column address width
- AREF_CNT, 1040, sys_clk cycles between refresh requests (7.8 us at 133 MHz)
- AREF_CNT_WIDTH, 11, width of refresh timer

Ports:
- sys_clk  in  1  system clock, 133 MHz
- sys_rst  in  1  asynchronous active-high reset
- init_done  in  1  init sub-FSM finished (level, stays high)
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init
- init_ba  in  BA_BITS  bank address from init
- init_addr  in  ADDR_BITS  address from init
- aref_done  in  1  one-cycle pulse, refresh sequence complete
- aref_cmd  in  4  command from the aref sub-FSM
- aref_addr  in  ADDR_BITS  address from the aref sub-FSM
- wr_req  in  1  write request, level, held until wr_en seen
- wr_done  in  1  one-cycle pulse, write burst complete
- wr_cmd  in  4  command from the write sub-FSM
- wr_ba  in  BA_BITS  bank address from the write sub-FSM
- wr_addr  in  ADDR_BITS  address from the write sub-FSM
- rd_req  in  1  read request, level
- rd_done  in  1  one-cycle pulse, read burst complete
- rd_cmd  in  4  command from the read sub-FSM
- rd_ba  in  BA_BITS  bank address from the read sub-FSM
- rd_addr  in  ADDR_BITS  address from the read sub-FSM
- aref_en  out  1  grant to aref sub-FSM
- wr_en  out  1  grant to write sub-FSM
- rd_en  out  1  grant to read sub-FSM
- aref_req  out  1  refresh pending (sticky)
- aref_overrun  out  1  sticky error: refresh interval missed
- sdram_cmd  out  4  muxed command
- sdram_bank  out  BA_BITS  muxed bank address
- sdram_addr  out  ADDR_BITS  muxed address
- arb_state  out  3  current state, debug

Behaviour:
- Command encoding: NOP = 4'b0111.
- State codes: INIT=0, ARBIT=1, AREF=2, WRITE=3, READ=4; registered. Reset state is INIT.
- Reset values:
  - aref_en = wr_en = rd_en = 0.
  - aref_req = 0, aref_overrun = 0.
  - ref_cnt = 0.
  - last_wr flag = 0.
- Output mux (combinational, from the registered state):
  - INIT → init_* signals.
  - AREF → aref_cmd, sdram_bank = 0, aref_addr.
  - WRITE → wr_*; READ → rd_*.
  - ARBIT → NOP, bank 0, addr 0.
- Grant outputs: aref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ).
- Transitions:
  - INIT: init_done=1 → ARBIT next cycle.
  - ARBIT: one-cycle evaluation. aref_req → AREF; else both wr_req and rd_req: go to READ if last_wr=1, else WRITE; else wr_req → WRITE; else rd_req → READ; else stay in ARBIT.
  - AREF: aref_done → ARBIT.
  - WRITE: wr_done → ARBIT and set last_wr=1.
  - READ: rd_done → ARBIT and clear last_wr.
- A done pulse in a state other than the matching state is ignored.
- No preemption: a refresh request raised during WRITE/READ waits for that burst's done pulse and is then serviced first in ARBIT.
- Minimum gap: exactly one ARBIT cycle (NOP) between consecutive grants.
- Refresh timer:
  - ref_cnt is held at 0 while init_done=0.
  - After init_done it counts 0..AREF_CNT-1 and wraps, free-running; it is not reset by refresh.
  - At ref_cnt==AREF_CNT-1, aref_req is set the next cycle.
  - aref_req is cleared on aref_done while in AREF.
  - Timer terminal count with aref_req already 1 (and no same-cycle aref_done) sets aref_overrun; it is cleared only by reset.
  - Terminal count coinciding with aref_done: clear wins, then set → aref_req stays 1 (new request).
- Reset mid-operation: all grants drop immediately, the output goes to init_cmd in INIT state, and the timer clears.

Decomposition:
- Shared package sdr_pkg holds:
  - command encodings: CMD_NOP, CMD_PRE, CMD_AREF, CMD_ACT, CMD_WR, CMD_RD, CMD_MRS;
  - state codes;
  - BA_BITS/ADDR_BITS defaults.
- One natural sub-module, sdram_aref_timer: refresh counter plus aref_req/aref_overrun flags.
- Arbiter FSM and output mux live in the top of the block.

Test Plan:
- Reset, hold init_done=0 for 50 cycles → arb_state=0, sdram_cmd = init_cmd, all grants 0, ref_cnt 0. Raise init_done → arb_state=1 next cycle, sdram_cmd=4'b0111.
- AREF_CNT=64, no wr/rd → aref_req rises 64 cycles after init_done and aref_en one cycle later. aref_done → aref_req=0, ARBIT, next request 64 cycles after the previous one.
- wr_req and rd_req both held high from ARBIT, last_wr=0 → WRITE granted. wr_done → 1 ARBIT cycle → READ. Repeat → alternating W,R,W,R.
- aref_req set while in WRITE → WRITE continues until wr_done; next grant is AREF even with rd_req=1.
- Hold WRITE (no wr_done) for 130 cycles with AREF_CNT=64 → aref_overrun=1 at the second terminal count; it stays 1 after aref_done.
- Assert sys_rst while in READ → rd_en=0 asynchronously, arb_state=0, aref_req=0, aref_overrun=0.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter state codes
// and default bus widths.
package sdr_pkg;

   localparam int unsigned BA_BITS_DEF   = 2;
   localparam int unsigned ADDR_BITS_DEF = 12;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle between the init/aref/write/read sub-FSMs, the arbiter and the SDRAM
// pin drivers. master = arbiter side, slave = sub-FSM / pin side.
interface sdram_arbiter_if import sdr_pkg::*; #(
   parameter int unsigned BA_BITS   = BA_BITS_DEF,
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) ();

   logic                 init_done;
   logic [3:0]           init_cmd;
   logic [BA_BITS-1:0]   init_ba;
   logic [ADDR_BITS-1:0] init_addr;
   logic                 aref_done;
   logic [3:0]           aref_cmd;
   logic [ADDR_BITS-1:0] aref_addr;
   logic                 wr_req;
   logic                 wr_done;
   logic [3:0]           wr_cmd;
   logic [BA_BITS-1:0]   wr_ba;
   logic [ADDR_BITS-1:0] wr_addr;
   logic                 rd_req;
   logic                 rd_done;
   logic [3:0]           rd_cmd;
   logic [BA_BITS-1:0]   rd_ba;
   logic [ADDR_BITS-1:0] rd_addr;

   logic                 aref_en;
   logic                 wr_en;
   logic                 rd_en;
   logic                 aref_req;
   logic                 aref_overrun;
   logic [3:0]           sdram_cmd;
   logic [BA_BITS-1:0]   sdram_bank;
   logic [ADDR_BITS-1:0] sdram_addr;
   logic [2:0]           arb_state;

   modport master (
      input  init_done, init_cmd, init_ba, init_addr,
      input  aref_done, aref_cmd, aref_addr,
      input  wr_req, wr_done, wr_cmd, wr_ba, wr_addr,
      input  rd_req, rd_done, rd_cmd, rd_ba, rd_addr,
      output aref_en, wr_en, rd_en, aref_req, aref_overrun,
      output sdram_cmd, sdram_bank, sdram_addr, arb_state
   );

   modport slave (
      output init_done, init_cmd, init_ba, init_addr,
      output aref_done, aref_cmd, aref_addr,
      output wr_req, wr_done, wr_cmd, wr_ba, wr_addr,
      output rd_req, rd_done, rd_cmd, rd_ba, rd_addr,
      input  aref_en, wr_en, rd_en, aref_req, aref_overrun,
      input  sdram_cmd, sdram_bank, sdram_addr, arb_state
   );

endinterface

// File: rtl/sdram_aref_timer.sv
// Free-running refresh interval timer with the sticky refresh-request and
// overrun flags. The counter only runs once init has completed.
module sdram_aref_timer #(
   parameter int unsigned AREF_CNT       = 1040,
   parameter int unsigned AREF_CNT_WIDTH = 11
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic init_done,
   input  logic aref_clr,   // aref_done qualified by the AREF state
   output logic aref_req,
   output logic aref_overrun
);

   localparam logic [AREF_CNT_WIDTH-1:0] TC_VAL = AREF_CNT_WIDTH'(AREF_CNT - 1);

   logic [AREF_CNT_WIDTH-1:0] ref_cnt;
   logic                      tc;

   assign tc = init_done && (ref_cnt == TC_VAL);

   // Interval counter: held at zero until init completes, then wraps forever.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ref_cnt <= '0;
      end else if (!init_done || tc) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // Request flag: terminal count wins over a same-cycle clear (new request).
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         aref_req <= 1'b0;
      end else if (tc) begin
         aref_req <= 1'b1;
      end else if (aref_clr) begin
         aref_req <= 1'b0;
      end
   end

   // Overrun: a new interval elapsed while the previous request was unserved.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         aref_overrun <= 1'b0;
      end else if (tc && aref_req && !aref_clr) begin
         aref_overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command/address bus arbiter: grants init, refresh, write or read one
// at a time and muxes the granted source onto the SDRAM pins.
module sdram_arbiter import sdr_pkg::*; #(
   parameter int unsigned BA_BITS        = BA_BITS_DEF,
   parameter int unsigned ADDR_BITS      = ADDR_BITS_DEF,
   parameter int unsigned AREF_CNT       = 1040,
   parameter int unsigned AREF_CNT_WIDTH = 11
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   sdram_arbiter_if.master  bus
);

   arb_state_t           state_q, state_d;
   logic                 last_wr_q, last_wr_d;
   logic                 aref_clr;
   logic [3:0]           cmd_mux;
   logic [BA_BITS-1:0]   bank_mux;
   logic [ADDR_BITS-1:0] addr_mux;

   assign aref_clr = (state_q == ST_AREF) && bus.aref_done;

   sdram_aref_timer #(
      .AREF_CNT       (AREF_CNT),
      .AREF_CNT_WIDTH (AREF_CNT_WIDTH)
   ) u_aref_timer (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .init_done    (bus.init_done),
      .aref_clr     (aref_clr),
      .aref_req     (bus.aref_req),
      .aref_overrun (bus.aref_overrun)
   );

   // State and write/read fairness flag registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_INIT;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
      end
   end

   // Next state: ARBIT is a single NOP cycle between any two grants.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      case (state_q)
         ST_INIT: begin
            if (bus.init_done) state_d = ST_ARBIT;
         end
         ST_ARBIT: begin
            if (bus.aref_req) begin
               state_d = ST_AREF;
            end else if (bus.wr_req && bus.rd_req) begin
               // Alternate when both are pending so neither starves.
               state_d = last_wr_q ? ST_READ : ST_WRITE;
            end else if (bus.wr_req) begin
               state_d = ST_WRITE;
            end else if (bus.rd_req) begin
               state_d = ST_READ;
            end
         end
         ST_AREF: begin
            if (bus.aref_done) state_d = ST_ARBIT;
         end
         ST_WRITE: begin
            if (bus.wr_done) begin
               state_d   = ST_ARBIT;
               last_wr_d = 1'b1;
            end
         end
         ST_READ: begin
            if (bus.rd_done) begin
               state_d   = ST_ARBIT;
               last_wr_d = 1'b0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Pin mux driven from the registered state; ARBIT and unused codes give NOP.
   always_comb begin
      cmd_mux  = CMD_NOP;
      bank_mux = '0;
      addr_mux = '0;
      case (state_q)
         ST_INIT: begin
            cmd_mux  = bus.init_cmd;
            bank_mux = bus.init_ba;
            addr_mux = bus.init_addr;
         end
         ST_AREF: begin
            cmd_mux  = bus.aref_cmd;
            addr_mux = bus.aref_addr;
         end
         ST_WRITE: begin
            cmd_mux  = bus.wr_cmd;
            bank_mux = bus.wr_ba;
            addr_mux = bus.wr_addr;
         end
         ST_READ: begin
            cmd_mux  = bus.rd_cmd;
            bank_mux = bus.rd_ba;
            addr_mux = bus.rd_addr;
         end
         default: ;
      endcase
   end

   assign bus.sdram_cmd  = cmd_mux;
   assign bus.sdram_bank = bank_mux;
   assign bus.sdram_addr = addr_mux;
   assign bus.aref_en    = (state_q == ST_AREF);
   assign bus.wr_en      = (state_q == ST_WRITE);
   assign bus.rd_en      = (state_q == ST_READ);
   assign bus.arb_state  = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a 64-cycle refresh interval.
module tb_sdram_arbiter;

   logic sys_clk = 1'b0;
   logic sys_rst;
   int   checks   = 0;
   int   failures = 0;
   int   n        = 0;   // clock edges since the first init_done=1 edge

   always #5 sys_clk = ~sys_clk;

   sdram_arbiter_if #(.BA_BITS(2), .ADDR_BITS(12)) bus ();

   sdram_arbiter #(
      .BA_BITS        (2),
      .ADDR_BITS      (12),
      .AREF_CNT       (64),
      .AREF_CNT_WIDTH (11)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   typedef struct {
      logic       init_done;
      logic       aref_done;
      logic       wr_req;
      logic       wr_done;
      logic       rd_req;
      logic       rd_done;
      logic [2:0] exp_state;
      logic       exp_req;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected {cmd, bank, addr} for a given state with the fixed source values.
   function automatic logic [17:0] exp_pins(input logic [2:0] st);
      case (st)
         3'd0:    return {4'h1, 2'd1, 12'h111};
         3'd2:    return {4'h2, 2'd0, 12'h222};
         3'd3:    return {4'h3, 2'd2, 12'h333};
         3'd4:    return {4'h4, 2'd3, 12'h444};
         default: return {4'b0111, 2'd0, 12'h000};
      endcase
   endfunction

   task automatic check_state(input string name, input logic [2:0] st);
      chk({name, ".state"}, 32'(bus.arb_state), 32'(st));
      chk({name, ".grants"}, 32'({bus.aref_en, bus.wr_en, bus.rd_en}),
          32'({st == 3'd2, st == 3'd3, st == 3'd4}));
      chk({name, ".pins"}, 32'({bus.sdram_cmd, bus.sdram_bank, bus.sdram_addr}),
          32'(exp_pins(st)));
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      n++;
   endtask

   task automatic run_to(input int target);
      while (n < target) tick();
   endtask

   task automatic set_in(input vec_t v);
      bus.init_done = v.init_done;
      bus.aref_done = v.aref_done;
      bus.wr_req    = v.wr_req;
      bus.wr_done   = v.wr_done;
      bus.rd_req    = v.rd_req;
      bus.rd_done   = v.rd_done;
   endtask

   initial begin
      //          init aref wr  wrd  rd  rdd  state  req
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};

      sys_rst       = 1'b1;
      bus.init_done = 1'b0;
      bus.init_cmd  = 4'h1;  bus.init_ba = 2'd1;  bus.init_addr = 12'h111;
      bus.aref_done = 1'b0;
      bus.aref_cmd  = 4'h2;  bus.aref_addr = 12'h222;
      bus.wr_req    = 1'b0;  bus.wr_done = 1'b0;
      bus.wr_cmd    = 4'h3;  bus.wr_ba = 2'd2;    bus.wr_addr = 12'h333;
      bus.rd_req    = 1'b0;  bus.rd_done = 1'b0;
      bus.rd_cmd    = 4'h4;  bus.rd_ba = 2'd3;    bus.rd_addr = 12'h444;

      #1;
      check_state("reset", 3'd0);
      chk("reset.aref_req", 32'(bus.aref_req), 32'd0);
      chk("reset.overrun", 32'(bus.aref_overrun), 32'd0);
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;

      // Init held off: no timer activity, no grants.
      repeat (50) tick();
      check_state("init_hold", 3'd0);
      chk("init_hold.aref_req", 32'(bus.aref_req), 32'd0);

      n = 0;
      for (int i = 0; i < 18; i++) begin
         set_in(vecs[i]);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].exp_state);
         chk($sformatf("vec%0d.aref_req", i), 32'(bus.aref_req), 32'(vecs[i].exp_req));
      end

      // First refresh: request after 64 edges, grant one cycle later.
      run_to(63);
      chk("aref1.pre_req", 32'(bus.aref_req), 32'd0);
      tick();
      chk("aref1.req", 32'(bus.aref_req), 32'd1);
      check_state("aref1.eval", 3'd1);
      tick();
      check_state("aref1.grant", 3'd2);
      tick();
      check_state("aref1.hold", 3'd2);
      bus.aref_done = 1'b1;
      tick();
      bus.aref_done = 1'b0;
      check_state("aref1.done", 3'd1);
      chk("aref1.clr", 32'(bus.aref_req), 32'd0);

      // Second refresh exactly one interval later.
      run_to(127);
      chk("aref2.pre_req", 32'(bus.aref_req), 32'd0);
      tick();
      chk("aref2.req", 32'(bus.aref_req), 32'd1);
      tick();
      check_state("aref2.grant", 3'd2);
      bus.aref_done = 1'b1;
      tick();
      bus.aref_done = 1'b0;
      chk("aref2.clr", 32'(bus.aref_req), 32'd0);

      // Refresh raised during WRITE waits, then beats a pending read.
      run_to(184);
      bus.wr_req = 1'b1;
      tick();
      check_state("nopre.write", 3'd3);
      run_to(192);
      chk("nopre.req", 32'(bus.aref_req), 32'd1);
      check_state("nopre.still_write", 3'd3);
      tick();
      check_state("nopre.hold", 3'd3);
      bus.wr_done = 1'b1; bus.wr_req = 1'b0; bus.rd_req = 1'b1;
      tick();
      bus.wr_done = 1'b0;
      check_state("nopre.gap", 3'd1);
      tick();
      check_state("nopre.aref_first", 3'd2);
      bus.aref_done = 1'b1;
      tick();
      bus.aref_done = 1'b0;
      check_state("nopre.gap2", 3'd1);
      tick();
      check_state("nopre.read", 3'd4);
      bus.rd_done = 1'b1; bus.rd_req = 1'b0;
      tick();
      bus.rd_done = 1'b0;
      check_state("nopre.end", 3'd1);

      // Long write blocks refresh across two terminal counts -> overrun.
      run_to(199);
      bus.wr_req = 1'b1;
      tick();
      check_state("ovr.write", 3'd3);
      run_to(256);
      chk("ovr.req", 32'(bus.aref_req), 32'd1);
      run_to(319);
      chk("ovr.pre", 32'(bus.aref_overrun), 32'd0);
      tick();
      chk("ovr.set", 32'(bus.aref_overrun), 32'd1);
      run_to(330);
      check_state("ovr.still_write", 3'd3);
      bus.wr_done = 1'b1; bus.wr_req = 1'b0;
      tick();
      bus.wr_done = 1'b0;
      tick();
      check_state("ovr.aref", 3'd2);
      bus.aref_done = 1'b1;
      tick();
      bus.aref_done = 1'b0;
      chk("ovr.req_clr", 32'(bus.aref_req), 32'd0);
      chk("ovr.sticky", 32'(bus.aref_overrun), 32'd1);

      // aref_done on the same edge as terminal count: request survives.
      run_to(384);
      chk("coin.req", 32'(bus.aref_req), 32'd1);
      tick();
      check_state("coin.aref", 3'd2);
      run_to(447);
      bus.aref_done = 1'b1;
      tick();
      bus.aref_done = 1'b0;
      check_state("coin.gap", 3'd1);
      chk("coin.req_kept", 32'(bus.aref_req), 32'd1);
      tick();
      check_state("coin.regrant", 3'd2);
      bus.aref_done = 1'b1;
      tick();
      bus.aref_done = 1'b0;
      chk("coin.req_clr", 32'(bus.aref_req), 32'd0);

      // Asynchronous reset mid-READ.
      bus.rd_req = 1'b1;
      tick();
      check_state("rst.read", 3'd4);
      #2 sys_rst = 1'b1;
      #1;
      check_state("rst.mid", 3'd0);
      chk("rst.aref_req", 32'(bus.aref_req), 32'd0);
      chk("rst.overrun", 32'(bus.aref_overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
